mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the core's shared `mux` (`DATA_WIDTH`/`INPUTS` parameterised N:1 selector). Up to `INPUTS` requesters compete for the mux. The arbiter grants one requester at a time, drives the mux `addr` select, and holds the grant for a multi-beat transaction until the requester's last beat or until it withdraws its request. A valid/ready handshake qualifies each beat towards the downstream consumer of the mux output.

---
 rtl/mux_rr_arbiter.sv | 97 +++++++++
 tb/tb_mux_rr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter and sequencer driving a shared N:1 mux select
module mux_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int INPUTS     = 4,
    parameter int ADDR_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [INPUTS-1:0]     i_req,
    input  logic [INPUTS-1:0]     i_last,
    input  logic                  i_out_ready,
    output logic [ADDR_WIDTH-1:0] o_sel,
    output logic [INPUTS-1:0]     o_grant,
    output logic                  o_out_valid,
    output logic [INPUTS-1:0]     o_ack,
    output logic                  o_busy
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    // DATA_WIDTH only sizes the mux datapath that o_sel steers; it is
    // referenced here so a nonsensical width is at least visible at elaboration.
    if (DATA_WIDTH < 1) begin : g_data_width_invalid
    end

    logic                  r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_sel;
    logic [INPUTS-1:0]     r_grant;

    logic [ADDR_WIDTH-1:0] w_pick;
    logic [INPUTS-1:0]     w_pick_oh;
    logic                  w_any_req;
    logic                  w_req_sel;
    logic                  w_last_sel;
    logic                  w_xfer;
    logic                  w_end;

    // Round-robin search: first set request at ptr+1, ptr+2, ... wrapping at
    // INPUTS. Iterating from the farthest offset down lets the nearest win.
    always_comb begin
        w_pick    = '0;
        w_pick_oh = '0;
        for (int k = INPUTS; k >= 1; k--) begin
            if (i_req[(int'(r_ptr) + k) % INPUTS]) begin
                w_pick    = ADDR_WIDTH'((int'(r_ptr) + k) % INPUTS);
                w_pick_oh = INPUTS'(1) << ((int'(r_ptr) + k) % INPUTS);
            end
        end
    end

    assign w_any_req = |i_req;

    // The grant vector is one-hot on the selected requester while busy and
    // zero otherwise, so masking with it picks req/last of the owner only.
    assign w_req_sel  = |(i_req & r_grant);
    assign w_last_sel = |(i_last & r_grant);

    assign o_busy      = (r_state == ST_GRANT);
    assign o_out_valid = o_busy && w_req_sel;
    assign w_xfer      = o_out_valid && i_out_ready;
    assign o_ack       = w_xfer ? r_grant : '0;
    assign w_end       = !w_req_sel || (w_xfer && w_last_sel);

    assign o_sel   = r_sel;
    assign o_grant = r_grant;

    // Arbitration and transaction tracking; sel is left untouched when a
    // transaction ends so the mux path stays stable through the idle bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= ADDR_WIDTH'(INPUTS - 1);
            r_sel   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_GRANT;
                        r_sel   <= w_pick;
                        r_ptr   <= w_pick;
                        r_grant <= w_pick_oh;
                    end
                end
                default: begin
                    if (w_end) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    localparam int INPUTS = 4;
    localparam int AW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [INPUTS-1:0] req;
    logic [INPUTS-1:0] last;
    logic              out_ready;
    logic [AW-1:0]     sel;
    logic [INPUTS-1:0] grant;
    logic              out_valid;
    logic [INPUTS-1:0] ack;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    mux_rr_arbiter #(.DATA_WIDTH(8), .INPUTS(INPUTS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_last      (last),
        .i_out_ready (out_ready),
        .o_sel       (sel),
        .o_grant     (grant),
        .o_out_valid (out_valid),
        .o_ack       (ack),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_grant, input logic [1:0] e_sel,
                           input logic e_busy, input logic e_valid, input logic [3:0] e_ack);
        chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
        chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
    endtask

    logic [1:0] rr_order [5];

    initial begin
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = '0; last = '0; out_ready = 1'b0; rst = 1'b0;

        // reset applied between edges acts without a clock
        #2 rst = 1'b1;
        #1 chk_all("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
        step(); step();
        rst = 1'b0;

        // idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("idle", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
        end

        // single requester, three beats
        req = 4'b0100; out_ready = 1'b1;
        step();
        chk_all("single.b1", 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100);
        step();
        chk_all("single.b2", 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100);
        step();
        last = 4'b0100;
        #1 chk_all("single.b3", 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100);
        step();
        req = '0; last = '0;
        #1 chk_all("single.end", 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0000);

        // round robin from a fresh pointer, one beat per transaction
        rst = 1'b1;
        #1 chk_all("rr.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
        step();
        rst = 1'b0;
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("rr.grant", 4'b0001 << rr_order[i], rr_order[i], 1'b1, 1'b1, 4'b0001 << rr_order[i]);
            step();
            chk("rr.bubble.busy", 32'(busy), 32'd0);
            chk("rr.bubble.sel", 32'(sel), 32'(rr_order[i]));
        end
        req = '0; last = '0;

        // backpressure on requester 1 with last held high
        req = 4'b0010; last = 4'b0010; out_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_all("stall", 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000);
            step();
        end
        out_ready = 1'b1;
        #1 chk_all("stall.release", 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0010);
        step();
        req = '0; last = '0;
        #1 chk_all("stall.end", 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000);

        // move the pointer to 3 so requester 0 wins next
        req = 4'b1000; last = 4'b1000;
        step();
        chk_all("pre_abort", 4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000);
        step();
        last = '0;

        // abort: requester 0 drops its request mid-transaction
        req = 4'b1001;
        step();
        chk_all("abort.b1", 4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001);
        req = 4'b1000;
        #1 chk_all("abort.drop", 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000);
        step();
        req = 4'b1001;
        #1 chk_all("abort.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
        step();
        chk_all("abort.fair", 4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000);
        last = 4'b1000;
        step();
        req = '0; last = '0;
        #1 chk("fair.end.busy", 32'(busy), 32'd0);

        // reset in the middle of a grant to requester 2
        req = 4'b0100;
        step();
        chk_all("mid.grant", 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100);
        #2 rst = 1'b1;
        #1 chk_all("mid.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
        step();
        rst = 1'b0; req = 4'b0101;
        #1 chk_all("mid.rel", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
        step();
        chk_all("mid.first", 4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
